// File: rtl/sram_pkg.sv
// Purpose: shared types and sizes for the SRAM access responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int BEATS   = 4;   // SRAM words per block
    localparam int WORD_W  = 16;  // SRAM data bus width
    localparam int BLOCK_W = 64;  // DES block width
    localparam int BEAT_W  = 2;   // width of the beat index

endpackage

// File: rtl/sram_wait_timer.sv
// Purpose: loadable down-counter timing the strobe-low (ACCESS) phase of one SRAM word.
// Latency: tc asserts CNT cycles after a load of CNT; tc is decoded from the count register.
// Backpressure: none; load always wins, the count stops at zero.
// Ports: clk/n_rst (sync active-low), load + load_val (start a count), tc (count is zero).
module sram_wait_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/sram_access_responder.sv
// Purpose: accepts one-cycle block write/read requests and runs a 16-bit async SRAM, 4 words per block.
// Latency: accept at edge k -> wr_done/rd_valid high from edge k+4*(1+WAIT_CYC) for one cycle.
// Backpressure: none; requests arriving while busy (except in the DONE cycle) are dropped with req_err.
// Ports: req_* / wr_data from the address generator; rd_data/rd_valid/wr_done/busy/req_err back to the
//        controller; sram_* drive the SRAM pads. Every output comes straight from a flop.
module sram_access_responder
    import sram_pkg::*;
#(
    parameter int WAIT_CYC = 2,
    parameter int ADDR_W   = 16
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [ADDR_W-1:0]  req_address,
    input  logic               req_write_en,
    input  logic               req_read_en,
    input  logic [BLOCK_W-1:0] wr_data,
    input  logic [WORD_W-1:0]  sram_rdata,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [WORD_W-1:0]  sram_wdata,
    output logic               sram_ce_n,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic [BLOCK_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               wr_done,
    output logic               busy,
    output logic               req_err
);

    state_t               state_q,      state_d;
    logic [BEAT_W-1:0]    beat_q,       beat_d;
    logic [ADDR_W-1:0]    base_q,       base_d;
    logic                 is_wr_q,      is_wr_d;
    logic [BLOCK_W-1:0]   wbuf_q,       wbuf_d;
    logic [BLOCK_W-1:0]   shadow_q,     shadow_d;
    logic [BLOCK_W-1:0]   rd_data_q,    rd_data_d;
    logic                 rd_valid_q,   rd_valid_d;
    logic                 wr_done_q,    wr_done_d;
    logic                 req_err_q,    req_err_d;
    logic                 busy_q,       busy_d;
    logic [ADDR_W-1:0]    sram_addr_q,  sram_addr_d;
    logic [WORD_W-1:0]    sram_wdata_q, sram_wdata_d;
    logic                 sram_ce_n_q,  sram_ce_n_d;
    logic                 sram_we_n_q,  sram_we_n_d;
    logic                 sram_oe_n_q,  sram_oe_n_d;

    logic accept;
    logic bus_active;
    logic wait_tc;

    sram_wait_timer #(.CNT_W(4)) u_wait_timer (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (state_q == ST_SETUP),
        .load_val (4'(WAIT_CYC - 1)),
        .tc       (wait_tc)
    );

    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        base_d     = base_q;
        is_wr_d    = is_wr_q;
        wbuf_d     = wbuf_q;
        shadow_d   = shadow_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        wr_done_d  = 1'b0;

        // The DONE cycle doubles as an idle slot so back-to-back blocks lose no cycle.
        accept    = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && (req_write_en ^ req_read_en);
        req_err_d = (req_write_en || req_read_en) && !accept;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    state_d = ST_SETUP;
                    base_d  = req_address;
                    is_wr_d = req_write_en;
                    wbuf_d  = wr_data;
                    beat_d  = '0;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (wait_tc) begin
                    // Words arrive MSB first, so shifting in from the bottom assembles the block.
                    if (!is_wr_q) begin
                        shadow_d = {shadow_q[BLOCK_W-WORD_W-1:0], sram_rdata};
                    end
                    if (beat_q == BEAT_W'(BEATS - 1)) begin
                        state_d = ST_DONE;
                        if (is_wr_q) begin
                            wr_done_d = 1'b1;
                        end else begin
                            rd_data_d  = shadow_d;
                            rd_valid_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_SETUP;
                        beat_d  = beat_q + 1'b1;
                        wbuf_d  = wbuf_q << WORD_W;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are decoded from the next state so the pads change on the same edge as the FSM.
        bus_active   = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
        sram_ce_n_d  = !bus_active;
        sram_we_n_d  = !((state_d == ST_ACCESS) && is_wr_d);
        sram_oe_n_d  = !(bus_active && !is_wr_d);
        busy_d       = (state_d != ST_IDLE);
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        // Address and write data move only on entry to SETUP, while we_n is high.
        if (state_d == ST_SETUP) begin
            sram_addr_d = base_d + ADDR_W'(beat_d);
            if (is_wr_d) begin
                sram_wdata_d = wbuf_d[BLOCK_W-1 -: WORD_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            base_q       <= '0;
            is_wr_q      <= 1'b0;
            wbuf_q       <= '0;
            shadow_q     <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            wr_done_q    <= 1'b0;
            req_err_q    <= 1'b0;
            busy_q       <= 1'b0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            sram_ce_n_q  <= 1'b1;
            sram_we_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            base_q       <= base_d;
            is_wr_q      <= is_wr_d;
            wbuf_q       <= wbuf_d;
            shadow_q     <= shadow_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            wr_done_q    <= wr_done_d;
            req_err_q    <= req_err_d;
            busy_q       <= busy_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_ce_n_q  <= sram_ce_n_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_oe_n_q  <= sram_oe_n_d;
        end
    end

    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_ce_n  = sram_ce_n_q;
    assign sram_we_n  = sram_we_n_q;
    assign sram_oe_n  = sram_oe_n_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign wr_done    = wr_done_q;
    assign busy       = busy_q;
    assign req_err    = req_err_q;

endmodule
